multi_lane_issue_stage: RTL

// Parametrised N-lane issue stage between the scheduler's select logic and the register-read stage.

---
 rtl/multi_lane_issue_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/multi_lane_issue_stage.sv
// N-lane issue stage: IQ payload read, selective flush,
// replay history and saturating performance counters.
module multi_lane_issue_stage #(
   parameter int ISSUE_WIDTH  = 2,
   parameter int IQ_IDX_W     = 4,
   parameter int AL_PTR_W     = 6,
   parameter int PAYLOAD_W    = 64,
   parameter int REPLAY_DEPTH = 3,
   parameter int CNT_W        = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic                             clear,
   input  logic [ISSUE_WIDTH-1:0]           in_valid,
   input  logic [ISSUE_WIDTH*IQ_IDX_W-1:0]  in_iq_ptr,
   output logic [ISSUE_WIDTH*IQ_IDX_W-1:0]  iq_read_ptr,
   input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] iq_read_data,
   input  logic                             to_recovery,
   input  logic [AL_PTR_W-1:0]              flush_head,
   input  logic [AL_PTR_W-1:0]              flush_tail,
   input  logic                             flush_all,
   input  logic                             replay_req,
   output logic [ISSUE_WIDTH-1:0]           iq_issue,
   output logic [ISSUE_WIDTH*IQ_IDX_W-1:0]  iq_issue_ptr,
   output logic [ISSUE_WIDTH-1:0]           out_valid,
   output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] out_payload,
   output logic [CNT_W-1:0]                 cnt_issue,
   output logic [CNT_W-1:0]                 cnt_replay,
   output logic [CNT_W-1:0]                 cnt_flush
);

   localparam int PW   = ISSUE_WIDTH * PAYLOAD_W;
   localparam int XW   = ISSUE_WIDTH * IQ_IDX_W;
   localparam int PC_W = $clog2(ISSUE_WIDTH + 1);
   localparam int SW   = CNT_W + 1;

   logic [ISSUE_WIDTH-1:0] valid_q, valid_d;
   logic [XW-1:0]          ptr_q, ptr_d;
   logic [ISSUE_WIDTH-1:0] hist_v_q [REPLAY_DEPTH];
   logic [ISSUE_WIDTH-1:0] hist_v_d [REPLAY_DEPTH];
   logic [PW-1:0]          hist_p_q [REPLAY_DEPTH];
   logic [PW-1:0]          hist_p_d [REPLAY_DEPTH];
   logic [CNT_W-1:0]       cnt_issue_q, cnt_issue_d;
   logic [CNT_W-1:0]       cnt_replay_q, cnt_replay_d;
   logic [CNT_W-1:0]       cnt_flush_q, cnt_flush_d;

   logic [ISSUE_WIDTH-1:0] cand, src_hit, reg_hit;
   logic [ISSUE_WIDTH-1:0] kill, iss, ov;
   logic [PW-1:0]          sel_pay;

   function automatic logic flush_hit(
      input logic [AL_PTR_W-1:0] p,
      input logic                rec,
      input logic                all,
      input logic [AL_PTR_W-1:0] h,
      input logic [AL_PTR_W-1:0] t
   );
      logic rng;
      if (h <= t) rng = (p >= h) && (p < t);
      else        rng = (p >= h) || (p < t);
      return rec && (all || rng);
   endfunction

   function automatic logic [PC_W-1:0] popcnt(
      input logic [ISSUE_WIDTH-1:0] v
   );
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++)
         c = c + PC_W'(v[i]);
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] a,
      input logic [PC_W-1:0]  b
   );
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   // Per-lane source select (IQ or replay history) and kill rule
   always_comb begin
      cand    = '0;
      src_hit = '0;
      reg_hit = '0;
      kill    = '0;
      iss     = '0;
      ov      = '0;
      sel_pay = replay_req ? hist_p_q[REPLAY_DEPTH-1]
                           : iq_read_data;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         cand[i] = replay_req ? hist_v_q[REPLAY_DEPTH-1][i]
                              : (valid_q[i] && !stall);
         src_hit[i] = flush_hit(
            sel_pay[i*PAYLOAD_W +: AL_PTR_W],
            to_recovery, flush_all, flush_head, flush_tail);
         reg_hit[i] = flush_hit(
            iq_read_data[i*PAYLOAD_W +: AL_PTR_W],
            to_recovery, flush_all, flush_head, flush_tail);
         kill[i] = cand[i] && !clear && src_hit[i];
         ov[i]   = rst && cand[i] && !clear && !src_hit[i];
         iss[i]  = ov[i] && !replay_req;
      end
   end

   // Pipeline register: clear, load, or hold with flush pruning
   always_comb begin
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (clear) begin
         valid_d = '0;
      end else if (!stall && !replay_req) begin
         valid_d = in_valid;
         ptr_d   = in_iq_ptr;
      end else begin
         valid_d = valid_q & ~reg_hit;
      end
   end

   // Replay history shifts in every presented group
   always_comb begin
      hist_v_d[0] = ov;
      hist_p_d[0] = sel_pay;
      for (int k = 1; k < REPLAY_DEPTH; k++) begin
         hist_v_d[k] = hist_v_q[k-1];
         hist_p_d[k] = hist_p_q[k-1];
      end
   end

   // Saturating event counters
   always_comb begin
      cnt_issue_d  = sat_add(cnt_issue_q, popcnt(iss));
      cnt_replay_d = sat_add(cnt_replay_q,
                             popcnt(ov & {ISSUE_WIDTH{replay_req}}));
      cnt_flush_d  = sat_add(cnt_flush_q, popcnt(kill));
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q      <= '0;
         ptr_q        <= '0;
         cnt_issue_q  <= '0;
         cnt_replay_q <= '0;
         cnt_flush_q  <= '0;
         for (int k = 0; k < REPLAY_DEPTH; k++) begin
            hist_v_q[k] <= '0;
            hist_p_q[k] <= '0;
         end
      end else begin
         valid_q      <= valid_d;
         ptr_q        <= ptr_d;
         cnt_issue_q  <= cnt_issue_d;
         cnt_replay_q <= cnt_replay_d;
         cnt_flush_q  <= cnt_flush_d;
         for (int k = 0; k < REPLAY_DEPTH; k++) begin
            hist_v_q[k] <= hist_v_d[k];
            hist_p_q[k] <= hist_p_d[k];
         end
      end
   end

   assign iq_read_ptr  = ptr_q;
   assign iq_issue_ptr = ptr_q;
   assign iq_issue     = iss;
   assign out_valid    = ov;
   assign out_payload  = sel_pay;
   assign cnt_issue    = cnt_issue_q;
   assign cnt_replay   = cnt_replay_q;
   assign cnt_flush    = cnt_flush_q;

endmodule
